// File: rtl/addsub_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM encodings, the
// sub-select encoding and the saturation limit helper.
package addsub_pkg;

    localparam logic SUB_ADD = 1'b0;
    localparam logic SUB_SUB = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } state_t;

    // Two's-complement saturation bound for a width-bit result (width <= 64);
    // neg=1 gives the most negative value, neg=0 the most positive.
    function automatic logic [63:0] sat_limit(input int unsigned width, input logic neg);
        logic [63:0] msb;
        msb = 64'd1 << (width - 1);
        return neg ? msb : (msb - 64'd1);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder slice; c_msb is the carry into the
// slice MSB so the top can form signed overflow on the final slice.
module addsub_chunk
    import addsub_pkg::*;
#(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_slice,
    input  logic [CHUNK-1:0] b_slice,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    always_comb begin
        logic [CHUNK:0] c;
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            sum[i]   = a_slice[i] ^ b_slice[i] ^ c[i];
            c[i + 1] = (a_slice[i] & b_slice[i]) | (c[i] & (a_slice[i] ^ b_slice[i]));
        end
        cout  = c[CHUNK];
        c_msb = c[CHUNK-1];
    end

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock LSB first.
// Optional ADDSUB_SAT_EN clamps the result to the signed range on overflow.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [CHUNK-1:0] a_sl, b_sl, sum_sl;
    logic             c_out_sl, c_msb_sl, last, ovf_now;
    logic [WIDTH-1:0] res_full, res_final;

    assign a_sl = a_q[cnt_q*CHUNK +: CHUNK];
    assign b_sl = b_q[cnt_q*CHUNK +: CHUNK];
    assign last = (cnt_q == CW'(NCHUNK - 1));

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_slice (a_sl),
        .b_slice (b_sl),
        .cin     (carry_q),
        .sum     (sum_sl),
        .cout    (c_out_sl),
        .c_msb   (c_msb_sl)
    );

`ifdef ADDSUB_SAT_EN
    localparam logic [63:0]      SAT_MAX64 = sat_limit(WIDTH, 1'b0);
    localparam logic [63:0]      SAT_MIN64 = sat_limit(WIDTH, 1'b1);
    localparam logic [WIDTH-1:0] SAT_MAX   = SAT_MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MIN   = SAT_MIN64[WIDTH-1:0];
`endif

    // Partial sums build up in acc_q so s only ever shows a finished result.
    always_comb begin
        res_full = acc_q;
        res_full[cnt_q*CHUNK +: CHUNK] = sum_sl;
        ovf_now = c_msb_sl ^ c_out_sl;
`ifdef ADDSUB_SAT_EN
        res_final = res_full;
        if (ovf_now) res_final = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
`else
        res_final = res_full;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = (sub == SUB_SUB) ? ~b : b;
                    carry_d = (sub == SUB_SUB) ? ~cin : cin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d   = res_full;
                carry_d = c_out_sl;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    s_d     = res_final;
                    cout_d  = c_out_sl;
                    ovf_d   = ovf_now;
                    zero_d  = (res_final == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
